// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment scanner.
// Each rising edge of the slow scan_tick advances one digit. A blanking gap
// separates consecutive digits. The displayed value is captured once per frame,
// when digit 0 is shown, so that mid-frame input changes never tear the display.
// All outputs are registered and active-low.
module seg_scan #(
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] BCNT_LOAD = 8'(BLANK_CYCLES - 1);

  // Hex digit to active-low cathodes {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        s1_q, s1_d, s2_q, s2_d, d_q, d_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [15:0] snap_val_q, snap_val_d;
  logic [3:0]  snap_dp_q, snap_dp_d;
  logic [3:0]  snap_en_q, snap_en_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        fs_q, fs_d;

  logic        tick_edge;
  logic [15:0] src_val;
  logic [3:0]  src_dp;
  logic [3:0]  src_en;

  assign tick_edge = s2_q & ~d_q;

  // Next-state, datapath and output decode.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    s1_d       = scan_tick;
    s2_d       = s1_q;
    d_d        = s2_q;
    state_d    = state_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
    an_d       = an_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    fs_d       = 1'b0;

    // Digit 0 shows the live inputs it captures; later digits use the snapshot.
    src_val = (idx_q == 2'd0) ? value    : snap_val_q;
    src_dp  = (idx_q == 2'd0) ? dp_in    : snap_dp_q;
    src_en  = (idx_q == 2'd0) ? digit_en : snap_en_q;

    case (state_q)
      ST_BLANK: begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (bcnt_q != 8'd0) begin
          bcnt_d = bcnt_q - 8'd1;
        end else begin
          state_d = ST_SHOW;
          an_d    = src_en[idx_q] ? ~(4'b0001 << idx_q) : 4'hF;
          seg_d   = hex_decode(src_val[{idx_q, 2'b00} +: 4]);
          dp_d    = ~src_dp[idx_q];
          if (idx_q == 2'd0) begin
            snap_val_d = value;
            snap_dp_d  = dp_in;
            snap_en_d  = digit_en;
            fs_d       = 1'b1;
          end
        end
      end
      default: begin // ST_SHOW: hold until the next scan edge
        if (tick_edge) begin
          state_d = ST_BLANK;
          an_d    = 4'hF;
          seg_d   = 7'h7F;
          dp_d    = 1'b1;
          idx_d   = idx_q + 2'd1;
          bcnt_d  = BCNT_LOAD;
        end
      end
    endcase
  end

  // State, synchronizer, datapath and output registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the snapshot registers are plain flops with a defined reset value, not a memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BLANK;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      d_q        <= 1'b0;
      idx_q      <= 2'd0;
      bcnt_q     <= BCNT_LOAD;
      snap_val_q <= 16'h0000;
      snap_dp_q  <= 4'h0;
      snap_en_q  <= 4'h0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      d_q        <= d_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      snap_en_q  <= snap_en_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule
